// File: rtl/vig_pkg.sv
// Shared types and ASCII helpers for the Vigenere keystream front end.
// Letters are 0..25 in LETTER_W bits; ASCII classification is pure arithmetic.
package vig_pkg;

  localparam int ALPHA    = 26;
  localparam int LETTER_W = 5;

  typedef enum logic [1:0] {
    NOKEY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Unsigned wrap-around makes anything below 'A' (or 'a') fail the range test.
  function automatic logic is_alpha(input logic [7:0] c);
    logic [7:0] u;
    logic [7:0] l;
    u = c - 8'h41;
    l = c - 8'h61;
    return (u < 8'(ALPHA)) || (l < 8'(ALPHA));
  endfunction

  function automatic logic [LETTER_W-1:0] ascii_to_letter(input logic [7:0] c);
    logic [7:0] d;
    if (c <= 8'h5A) begin
      d = c - 8'h41;
    end else begin
      d = c - 8'h61;
    end
    return d[LETTER_W-1:0];
  endfunction

endpackage

// File: rtl/vig_char_class.sv
// Combinational ASCII classifier: alpha flag, case flag and 0..25 letter index.
// Non-alpha characters report letter 0 and upper 0.
module vig_char_class
  import vig_pkg::*;
(
  input  logic [7:0]          ch,
  output logic                alpha,
  output logic                upper,
  output logic [LETTER_W-1:0] letter
);

  // Classify one character
  always_comb begin
    alpha  = is_alpha(ch);
    upper  = alpha & (ch <= 8'h5A);
    letter = alpha ? ascii_to_letter(ch) : {LETTER_W{1'b0}};
  end

endmodule

// File: rtl/vigenere_keystream_gen.sv
// Keyword store plus text classifier: emits (letter, key letter) pairs for alpha chars,
// passthrough records for everything else, through a single output register.
module vigenere_keystream_gen
  import vig_pkg::*;
#(
  parameter int KEY_MAX = 16,
  parameter int IDX_W   = $clog2(KEY_MAX)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                kl_valid,
  output logic                kl_ready,
  input  logic [7:0]          kl_char,
  input  logic                kl_last,
  input  logic                pt_valid,
  output logic                pt_ready,
  input  logic [7:0]          pt_char,
  output logic                o_valid,
  input  logic                o_ready,
  output logic [LETTER_W-1:0] o_letter,
  output logic [LETTER_W-1:0] o_key,
  output logic                o_upper,
  output logic                o_pass,
  output logic [7:0]          o_char,
  output logic [IDX_W:0]      key_len,
  output logic                key_err
);

  localparam logic [IDX_W:0] KEY_MAX_W = KEY_MAX[IDX_W:0];
  localparam logic [IDX_W:0] ONE_W     = {{IDX_W{1'b0}}, 1'b1};

  state_t                state_r;
  state_t                state_s;
  logic [LETTER_W-1:0]   key_r [KEY_MAX];
  logic [IDX_W:0]        wr_r;
  logic [IDX_W-1:0]      idx_r;

  logic                  kl_alpha_s;
  logic                  unused_kl_upper;
  logic [LETTER_W-1:0]   kl_letter_s;
  logic                  pt_alpha_s;
  logic                  pt_upper_s;
  logic [LETTER_W-1:0]   pt_letter_s;

  logic                  loading_s;
  logic [IDX_W:0]        wr_base_s;
  logic                  err_base_s;
  logic                  kl_fire_s;
  logic                  kl_wr_s;
  logic [IDX_W:0]        kl_count_s;
  logic                  pt_fire_s;
  logic                  idx_last_s;

  vig_char_class u_kl_class (
    .ch     (kl_char),
    .alpha  (kl_alpha_s),
    .upper  (unused_kl_upper),
    .letter (kl_letter_s)
  );

  vig_char_class u_pt_class (
    .ch     (pt_char),
    .alpha  (pt_alpha_s),
    .upper  (pt_upper_s),
    .letter (pt_letter_s)
  );

  // Handshake qualifiers; a load that starts from NOKEY/RUN sees a cleared pointer and error
  always_comb begin
    loading_s  = (state_r == LOAD);
    wr_base_s  = loading_s ? wr_r : {(IDX_W+1){1'b0}};
    err_base_s = loading_s ? key_err : 1'b0;
    kl_fire_s  = kl_valid & kl_ready;
    kl_wr_s    = kl_alpha_s & (wr_base_s < KEY_MAX_W);
    kl_count_s = wr_base_s + {{IDX_W{1'b0}}, kl_wr_s};
    pt_fire_s  = pt_valid & pt_ready;
    idx_last_s = ({1'b0, idx_r} == (key_len - ONE_W));
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= NOKEY;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: any accepted key letter moves toward LOAD, kl_last commits
  always_comb begin
    state_s = state_r;
    case (state_r)
      NOKEY, LOAD, RUN: begin
        if (kl_fire_s) begin
          if (kl_last) begin
            state_s = (kl_count_s != {(IDX_W+1){1'b0}}) ? RUN : NOKEY;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = NOKEY;
    endcase
  end

  // FSM outputs; in RUN a waiting text char wins over a rekey request
  always_comb begin
    kl_ready = 1'b0;
    pt_ready = 1'b0;
    case (state_r)
      NOKEY, LOAD: begin
        kl_ready = 1'b1;
        pt_ready = 1'b0;
      end
      RUN: begin
        kl_ready = ~o_valid & ~pt_valid;
        pt_ready = ~o_valid | o_ready;
      end
      default: begin
        kl_ready = 1'b0;
        pt_ready = 1'b0;
      end
    endcase
  end

  // Key store, write pointer, committed length and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < KEY_MAX; i++) begin
        key_r[i] <= {LETTER_W{1'b0}};
      end
      wr_r    <= {(IDX_W+1){1'b0}};
      key_len <= {(IDX_W+1){1'b0}};
      key_err <= 1'b0;
    end else if (kl_fire_s) begin
      if (kl_wr_s) begin
        key_r[wr_base_s[IDX_W-1:0]] <= kl_letter_s;
      end
      wr_r    <= kl_count_s;
      key_err <= err_base_s | ~kl_wr_s;
      key_len <= kl_last ? kl_count_s : {(IDX_W+1){1'b0}};
    end
  end

  // Output register and cyclic key read index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_r    <= {IDX_W{1'b0}};
      o_valid  <= 1'b0;
      o_letter <= {LETTER_W{1'b0}};
      o_key    <= {LETTER_W{1'b0}};
      o_upper  <= 1'b0;
      o_pass   <= 1'b0;
      o_char   <= 8'h00;
    end else begin
      if (kl_fire_s) begin
        idx_r <= {IDX_W{1'b0}};
      end else if (pt_fire_s && pt_alpha_s) begin
        idx_r <= idx_last_s ? {IDX_W{1'b0}} : idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
      end
      if (pt_fire_s) begin
        o_valid  <= 1'b1;
        o_letter <= pt_letter_s;
        o_key    <= pt_alpha_s ? key_r[idx_r] : {LETTER_W{1'b0}};
        o_upper  <= pt_upper_s;
        o_pass   <= ~pt_alpha_s;
        o_char   <= pt_char;
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vigenere_keystream_gen.sv
// Randomized bench for vigenere_keystream_gen with a queue-based keystream model:
// key letter for the n-th alpha char since load is key[n mod len].
module tb_vigenere_keystream_gen;

  localparam int KEY_MAX = 16;
  localparam int IDX_W   = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             kl_valid = 1'b0;
  logic             kl_ready;
  logic [7:0]       kl_char = 8'h00;
  logic             kl_last = 1'b0;
  logic             pt_valid = 1'b0;
  logic             pt_ready;
  logic [7:0]       pt_char = 8'h00;
  logic             o_valid;
  logic             o_ready = 1'b0;
  logic [4:0]       o_letter;
  logic [4:0]       o_key;
  logic             o_upper;
  logic             o_pass;
  logic [7:0]       o_char;
  logic [IDX_W:0]   key_len;
  logic             key_err;

  vigenere_keystream_gen #(.KEY_MAX(KEY_MAX), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset),
    .kl_valid(kl_valid), .kl_ready(kl_ready), .kl_char(kl_char), .kl_last(kl_last),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_char(pt_char),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_letter(o_letter), .o_key(o_key), .o_upper(o_upper), .o_pass(o_pass), .o_char(o_char),
    .key_len(key_len), .key_err(key_err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          mkey[$];
  int          mlen = 0;
  bit          merr = 1'b0;
  int          acnt = 0;
  logic [19:0] expq[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_upper(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  function automatic bit m_lower(input logic [7:0] c);
    return (c >= 8'h61) && (c <= 8'h7A);
  endfunction

  task automatic m_push(input logic [7:0] c);
    logic [19:0] e;
    if (m_upper(c)) begin
      e = {5'(c - 8'h41), 5'(mkey[acnt % mlen]), 1'b1, 1'b0, c};
      acnt++;
    end else if (m_lower(c)) begin
      e = {5'(c - 8'h61), 5'(mkey[acnt % mlen]), 1'b0, 1'b0, c};
      acnt++;
    end else begin
      e = {5'd0, 5'd0, 1'b0, 1'b1, c};
    end
    expq.push_back(e);
  endtask

  // One clock of text traffic; transfers are decided by the model and the DUT is checked against it
  task automatic cycle(input logic pv, input logic [7:0] pc, input logic ordy, output bit acc);
    bit exp_ready;
    @(negedge clk);
    kl_valid = 1'b0; kl_last = 1'b0;
    pt_valid = pv; pt_char = pc; o_ready = ordy;
    #1;
    exp_ready = (mlen > 0) && ((expq.size() == 0) || ordy);
    check_eq("o_valid", o_valid, expq.size() > 0);
    check_eq("pt_ready", pt_ready, exp_ready);
    if (expq.size() > 0) begin
      if (ordy) begin
        check_eq("out", {o_letter, o_key, o_upper, o_pass, o_char}, expq[0]);
        void'(expq.pop_front());
      end else begin
        check_eq("hold", {o_letter, o_key, o_upper, o_pass, o_char}, expq[0]);
      end
    end
    acc = pv && exp_ready;
    if (acc) m_push(pc);
  endtask

  task automatic drain();
    bit a;
    int b = 0;
    while (expq.size() > 0 && b < 50) begin
      cycle(1'b0, 8'h00, 1'b1, a);
      b++;
    end
    check_eq("drain", expq.size(), 0);
  endtask

  task automatic send_text(input string s, input bit rnd);
    bit a;
    for (int i = 0; i < s.len(); i++) begin
      int b = 0;
      a = 1'b0;
      while (!a && b < 40) begin
        cycle(1'b1, s[i], rnd ? ($urandom_range(0, 3) != 0) : 1'b1, a);
        b++;
      end
      if (!a) check_eq("pt_accept_timeout", 0, 1);
    end
  endtask

  task automatic load_key(input string s);
    drain();
    mkey.delete(); merr = 1'b0; acnt = 0; mlen = 0;
    for (int i = 0; i < s.len(); i++) begin
      int b = 0;
      forever begin
        @(negedge clk);
        pt_valid = 1'b0; o_ready = 1'b1;
        kl_valid = 1'b1; kl_char = s[i]; kl_last = (i == s.len() - 1);
        #1;
        if (kl_ready) break;
        b++;
        if (b > 20) begin
          check_eq("kl_ready_timeout", 0, 1);
          break;
        end
      end
      if ((m_upper(s[i]) || m_lower(s[i])) && mkey.size() < KEY_MAX)
        mkey.push_back(m_upper(s[i]) ? int'(s[i]) - 65 : int'(s[i]) - 97);
      else
        merr = 1'b1;
    end
    @(negedge clk);
    kl_valid = 1'b0; kl_last = 1'b0;
    mlen = mkey.size();
    #1;
    check_eq("key_len", key_len, mlen);
    check_eq("key_err", key_err, merr);
  endtask

  function automatic logic [7:0] rand_char();
    string p;
    int r;
    p = " !.09@[`{~";
    r = $urandom_range(0, 9);
    if (r < 4) return 8'(8'h41 + $urandom_range(0, 25));
    if (r < 8) return 8'(8'h61 + $urandom_range(0, 25));
    return p[$urandom_range(0, p.len() - 1)];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_o_valid", o_valid, 0);
    check_eq("rst_key_len", key_len, 0);
    check_eq("rst_key_err", key_err, 0);
    check_eq("rst_kl_ready", kl_ready, 1);
    check_eq("rst_pt_ready", pt_ready, 0);
    @(negedge clk);
    reset = 1'b1;

    // Classic example, full throughput
    load_key("LEMON");
    send_text("ATTACKATDAWN", 1'b0);
    drain();

    // Mixed case and passthrough
    load_key("KEY");
    send_text("a b!", 1'b0);
    drain();

    // Illegal key letters and overflow
    load_key("A1B");
    load_key("ABCDEFGHIJKLMNOPQ");
    load_key("KEY");
    load_key("1");
    cycle(1'b1, 8'h41, 1'b1, a);
    cycle(1'b1, 8'h41, 1'b1, a);

    // Downstream stall mid-stream
    load_key("LEMON");
    send_text("HE", 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h5A, 1'b0, a);
    send_text("LLOWORLD", 1'b0);
    drain();

    // Rekey after a partial key cycle, single-letter wrap
    load_key("LEMON");
    send_text("ATT", 1'b0);
    load_key("B");
    send_text("AA", 1'b0);
    drain();

    // Asynchronous reset with data in flight
    load_key("KEY");
    send_text("XYZ", 1'b0);
    @(negedge clk);
    pt_valid = 1'b1; pt_char = 8'h51; o_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_eq("mid_rst_o_valid", o_valid, 0);
    check_eq("mid_rst_key_len", key_len, 0);
    check_eq("mid_rst_pt_ready", pt_ready, 0);
    expq.delete(); mkey.delete(); mlen = 0; acnt = 0; merr = 1'b0;
    @(negedge clk);
    reset = 1'b1; pt_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h51, 1'b1, a);
    load_key("Q");
    send_text("QZ", 1'b0);
    drain();

    // Randomized keys and text with random back-pressure
    for (int it = 0; it < 8; it++) begin
      string k;
      string t;
      int kl;
      k = "";
      t = "";
      kl = $urandom_range(1, 18);
      for (int i = 0; i < kl; i++)
        k = {k, string'(($urandom_range(0, 9) == 0) ? 8'h37 : 8'(8'h41 + $urandom_range(0, 25)))};
      load_key(k);
      for (int i = 0; i < 40; i++) t = {t, string'(rand_char())};
      if (mlen > 0) send_text(t, 1'b1);
      else for (int i = 0; i < 3; i++) cycle(1'b1, 8'h41, 1'b1, a);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
